// File: rtl/seq_div_pkg.sv
// ---------------------------------------------------------------------------
// seq_div_pkg
// Shared definitions for the sequential 24/12 restoring divider.
//   N_DEF    : default divisor / quotient / remainder width
//   state_e  : divider control states
//   ERR_QUOT : quotient reported on divide-by-zero or overflow
// ---------------------------------------------------------------------------
package seq_div_pkg;

  localparam int N_DEF = 12;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ROUND,
    DONE
  } state_e;

  localparam logic [N_DEF-1:0] ERR_QUOT = {N_DEF{1'b1}};

endpackage : seq_div_pkg

// File: rtl/div_step_n.sv
// ---------------------------------------------------------------------------
// div_step_n
// One combinational restoring-division step.
// Ports:
//   r_i   : partial remainder entering the step (always < d_i)
//   bit_i : next dividend bit shifted into the remainder
//   d_i   : divisor
//   r_o   : partial remainder leaving the step (always < d_i)
//   q_o   : quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step_n
  import seq_div_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] r_i,
  input  logic         bit_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] r_o,
  output logic         q_o
);

  logic [N:0]   trial;
  logic [N-1:0] diff;

  // NOTE: every output of a combinational block is assigned on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    trial = {r_i, bit_i};
    // The compare must see the full N+1-bit trial value: its top bit is the
    // carry shifted out of the remainder.
    q_o   = (trial >= {1'b0, d_i});
    // When the subtraction is taken the true result is < d_i, so the low N
    // bits of the difference are exact.
    diff  = trial[N-1:0] - d_i;
    r_o   = q_o ? diff : trial[N-1:0];
  end

endmodule : div_step_n

// File: rtl/seq_divider_24_12.sv
// ---------------------------------------------------------------------------
// seq_divider_24_12
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient
// bit per clock, valid/ready handshake on input and output.
// Optional build macro: SEQ_DIV_ROUND_EN -- adds a ROUND state that rounds
// the quotient to nearest (saturating); remainder stays the truncated one.
// Ports:
//   clk, rst             : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake
//   dividend, divisor    : unsigned operands
//   out_valid / out_ready: result handshake
//   quotient, remainder  : unsigned result
//   div_zero, overflow   : error flags (quotient all-ones, remainder 0)
// ---------------------------------------------------------------------------
module seq_divider_24_12
  import seq_div_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_zero,
  output logic           overflow
);

  localparam int CW = $clog2(N + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [N-1:0]    d_q,     d_d;
  // Shift register: low dividend bits leave at the top, quotient bits enter
  // at the bottom, so after N steps it holds the quotient.
  logic [N-1:0]    q_q,     q_d;
  // The partial remainder is always < divisor, so its top (N+1th) bit is
  // always zero and is not stored.
  logic [N-1:0]    r_q,     r_d;
  logic            dz_q,    dz_d;
  logic            ov_q,    ov_d;

  logic [N-1:0]    step_r;
  logic            step_q;

  div_step_n #(.N(N)) u_step (
    .r_i   (r_q),
    .bit_i (q_q[N-1]),
    .d_i   (d_q),
    .r_o   (step_r),
    .q_o   (step_q)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    ov_d    = ov_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          d_d  = divisor;
          q_d  = dividend[N-1:0];
          r_d  = dividend[2*N-1:N];
          dz_d = 1'b0;
          ov_d = 1'b0;
          if (divisor == '0) begin
            dz_d    = 1'b1;
            q_d     = ERR_QUOT;
            r_d     = '0;
            state_d = DONE;
          end else if (dividend[2*N-1:N] >= divisor) begin
            // The quotient would need more than N bits.
            ov_d    = 1'b1;
            q_d     = ERR_QUOT;
            r_d     = '0;
            state_d = DONE;
          end else begin
            cnt_d   = CW'(N);
            state_d = CALC;
          end
        end
      end

      CALC: begin
        q_d   = {q_q[N-2:0], step_q};
        r_d   = step_r;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
`ifdef SEQ_DIV_ROUND_EN
          state_d = ROUND;
`else
          state_d = DONE;
`endif
        end
      end

`ifdef SEQ_DIV_ROUND_EN
      ROUND: begin
        // Round half up: 2*remainder >= divisor, evaluated on N+1 bits.
        if ({r_q, 1'b0} >= {1'b0, d_q}) begin
          q_d = (q_q == ERR_QUOT) ? q_q : q_q + N'(1);
        end
        state_d = DONE;
      end
`endif

      DONE: begin
        if (out_ready) begin
          dz_d    = 1'b0;
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = q_q;
  assign remainder = r_q;
  assign div_zero  = dz_q;
  assign overflow  = ov_q;

endmodule : seq_divider_24_12
